// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, mode constants and preset clamp for the timer core
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_SW  = 1'b0;
    localparam logic MODE_TMR = 1'b1;

    function automatic int unsigned clamp_field(input int unsigned value, input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/timer_count_pair.sv
// rtl/timer_count_pair.sv - two-field up/down counter with load, wrap and zero flags
module timer_count_pair #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_lsb_i,
    input  logic [W-1:0] load_msb_i,
    input  logic         step_i,
    input  logic         dir_i,
    input  logic [W-1:0] lsb_max_i,
    input  logic [W-1:0] msb_max_i,
    output logic [W-1:0] lsb_o,
    output logic [W-1:0] msb_o,
    output logic         wrap_o,
    output logic         zero_o
);

    logic [W-1:0] lsb_q, lsb_d;
    logic [W-1:0] msb_q, msb_d;

    // wrap_o / zero_o describe the step being taken this cycle, not the held value
    always_comb begin
        lsb_d  = lsb_q;
        msb_d  = msb_q;
        wrap_o = 1'b0;
        zero_o = 1'b0;
        if (load_i) begin
            lsb_d = load_lsb_i;
            msb_d = load_msb_i;
        end else if (step_i && !dir_i) begin
            if (lsb_q < lsb_max_i) begin
                lsb_d = lsb_q + W'(1);
            end else begin
                lsb_d = '0;
                if (msb_q < msb_max_i) begin
                    msb_d = msb_q + W'(1);
                end else begin
                    msb_d  = '0;
                    wrap_o = 1'b1;
                end
            end
        end else if (step_i && dir_i) begin
            if (lsb_q != '0) begin
                lsb_d = lsb_q - W'(1);
            end else if (msb_q != '0) begin
                msb_d = msb_q - W'(1);
                lsb_d = lsb_max_i;
            end
            zero_o = (lsb_d == '0) && (msb_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsb_q <= '0;
            msb_q <= '0;
        end else begin
            lsb_q <= lsb_d;
            msb_q <= msb_d;
        end
    end

    assign lsb_o = lsb_q;
    assign msb_o = msb_q;

endmodule

// File: rtl/multi_mode_timer_core.sv
// rtl/multi_mode_timer_core.sv - stopwatch/timer core with run/pause/done FSM, lap capture and flags
module multi_mode_timer_core
    import timer_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned SW_LSB_MAX  = 99,
    parameter int unsigned SW_MSB_MAX  = 99,
    parameter int unsigned TMR_LSB_MAX = 59,
    parameter int unsigned TMR_MSB_MAX = 99
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_en,
    input  logic         start_stop,
    input  logic         clear,
    input  logic         lap,
    input  logic         mode_sel,
    input  logic [W-1:0] preset_lsb,
    input  logic [W-1:0] preset_msb,
    output logic [W-1:0] lsb_out,
    output logic [W-1:0] msb_out,
    output logic [W-1:0] lap_lsb,
    output logic [W-1:0] lap_msb,
    output logic         lap_valid,
    output logic         running,
    output logic         done,
    output logic         alarm,
    output logic         overflow
);

    localparam longint unsigned FIELD_LIMIT = 64'd1 << W;

    if (SW_LSB_MAX >= FIELD_LIMIT || SW_MSB_MAX >= FIELD_LIMIT ||
        TMR_LSB_MAX >= FIELD_LIMIT || TMR_MSB_MAX >= FIELD_LIMIT) begin : g_width_check
        $error("multi_mode_timer_core: a terminal value does not fit in W bits");
    end

    state_e       state_q, state_d;
    logic         mode_q, mode_d;
    logic         ss_prev_q;
    logic         ss_rise;
    logic [W-1:0] lap_lsb_q, lap_msb_q;
    logic         lap_valid_q, lap_valid_d;
    logic         lap_cap;
    logic         done_q, done_d;
    logic         overflow_q, overflow_d;

    logic [W-1:0] init_lsb, init_msb;
    logic         init_zero;
    logic         cnt_load, cnt_step;
    logic [W-1:0] cnt_lsb, cnt_msb;
    logic [W-1:0] cnt_lsb_max;
    logic         cnt_wrap, cnt_zero;

    assign ss_rise = start_stop & ~ss_prev_q;

    // Init value follows the live mode_sel: it feeds the IDLE tracking and clear loads
    always_comb begin
        init_lsb = '0;
        init_msb = '0;
        if (mode_sel == MODE_TMR) begin
            init_lsb = W'(clamp_field(32'(preset_lsb), TMR_LSB_MAX));
            init_msb = W'(clamp_field(32'(preset_msb), TMR_MSB_MAX));
        end
    end

    assign init_zero   = (init_lsb == '0) && (init_msb == '0);
    assign cnt_lsb_max = (mode_q == MODE_TMR) ? W'(TMR_LSB_MAX) : W'(SW_LSB_MAX);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_load    = 1'b0;
        cnt_step    = 1'b0;
        lap_cap     = 1'b0;
        lap_valid_d = lap_valid_q;
        done_d      = 1'b0;
        overflow_d  = 1'b0;
        if (clear) begin
            state_d     = ST_IDLE;
            lap_valid_d = 1'b0;
            cnt_load    = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_load = 1'b1;
                    if (ss_rise) begin
                        mode_d = mode_sel;
                        if (mode_sel == MODE_TMR && init_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (ss_rise) begin
                        state_d = ST_PAUSE;
                    end else begin
                        if (lap) begin
                            lap_cap     = 1'b1;
                            lap_valid_d = 1'b1;
                        end
                        if (tick_en) begin
                            cnt_step = 1'b1;
                            if (mode_q == MODE_SW && cnt_wrap) begin
                                overflow_d = 1'b1;
                            end
                            if (mode_q == MODE_TMR && cnt_zero) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (ss_rise) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (ss_rise) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SW;
            ss_prev_q   <= 1'b0;
            lap_lsb_q   <= '0;
            lap_msb_q   <= '0;
            lap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ss_prev_q   <= start_stop;
            lap_valid_q <= lap_valid_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            if (lap_cap) begin
                lap_lsb_q <= cnt_lsb;
                lap_msb_q <= cnt_msb;
            end
        end
    end

    timer_count_pair #(
        .W (W)
    ) u_count (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_lsb_i (init_lsb),
        .load_msb_i (init_msb),
        .step_i     (cnt_step),
        .dir_i      (mode_q),
        .lsb_max_i  (cnt_lsb_max),
        .msb_max_i  (W'(SW_MSB_MAX)),
        .lsb_o      (cnt_lsb),
        .msb_o      (cnt_msb),
        .wrap_o     (cnt_wrap),
        .zero_o     (cnt_zero)
    );

    assign lsb_out   = cnt_lsb;
    assign msb_out   = cnt_msb;
    assign lap_lsb   = lap_lsb_q;
    assign lap_msb   = lap_msb_q;
    assign lap_valid = lap_valid_q;
    assign running   = (state_q == ST_RUN);
    assign alarm     = (state_q == ST_DONE);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_multi_mode_timer_core.sv
// tb/tb_multi_mode_timer_core.sv - directed self-checking bench for multi_mode_timer_core
module tb_multi_mode_timer_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic       mode_sel = 1'b0;
    logic [7:0] preset_lsb = 8'd0;
    logic [7:0] preset_msb = 8'd0;
    logic [7:0] lsb_out, msb_out, lap_lsb, lap_msb;
    logic       lap_valid, running, done, alarm, overflow;

    int checks = 0;
    int failures = 0;

    multi_mode_timer_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .mode_sel   (mode_sel),
        .preset_lsb (preset_lsb),
        .preset_msb (preset_msb),
        .lsb_out    (lsb_out),
        .msb_out    (msb_out),
        .lap_lsb    (lap_lsb),
        .lap_msb    (lap_msb),
        .lap_valid  (lap_valid),
        .running    (running),
        .done       (done),
        .alarm      (alarm),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ss, clr, lp, mode, tick;
        logic [7:0] pl, pm;
        logic [7:0] el, em;
        logic       er, ed, ea, eo, ev;
        logic [7:0] ell, elm;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic ss, input logic tk, input logic lp, input logic clr);
        start_stop = ss;
        tick_en    = tk;
        lap        = lp;
        clear      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm, input int idx, input logic [7:0] el, input logic [7:0] em);
        chk({nm, ".lsb"}, idx, 32'(lsb_out), 32'(el));
        chk({nm, ".msb"}, idx, 32'(msb_out), 32'(em));
    endtask

    initial begin
        // ss clr lap mode tick  pl  pm | lsb msb run done alarm ovf lapv lapl lapm
        vecs[0]  = '{0,0,0,1,0,  0,  0,   0,  0, 0,0,0,0,0, 10,3};
        vecs[1]  = '{1,0,0,1,0,  0,  0,   0,  0, 0,1,1,0,0, 10,3};
        vecs[2]  = '{0,0,0,1,1,  0,  0,   0,  0, 0,0,1,0,0, 10,3};
        vecs[3]  = '{1,0,0,1,0, 75,  5,   0,  0, 0,0,0,0,0, 10,3};
        vecs[4]  = '{0,0,0,1,0, 75,  5,  59,  5, 0,0,0,0,0, 10,3};
        vecs[5]  = '{0,0,0,1,0, 75,150,  59, 99, 0,0,0,0,0, 10,3};
        vecs[6]  = '{0,0,0,1,0, 12,  3,  12,  3, 0,0,0,0,0, 10,3};
        vecs[7]  = '{1,0,0,1,1, 12,  3,  12,  3, 1,0,0,0,0, 10,3};
        vecs[8]  = '{0,0,1,1,1, 12,  3,  11,  3, 1,0,0,0,1, 12,3};
        vecs[9]  = '{1,0,0,1,1, 12,  3,  11,  3, 0,0,0,0,1, 12,3};
        vecs[10] = '{0,0,1,1,1, 12,  3,  11,  3, 0,0,0,0,1, 12,3};
        vecs[11] = '{1,0,0,1,0, 12,  3,  11,  3, 1,0,0,0,1, 12,3};
        vecs[12] = '{0,0,0,0,1, 12,  3,  10,  3, 1,0,0,0,1, 12,3};
        vecs[13] = '{0,1,1,0,1, 12,  3,   0,  0, 0,0,0,0,0, 12,3};
        vecs[14] = '{0,0,0,0,0, 12,  3,   0,  0, 0,0,0,0,0, 12,3};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_cnt("reset", 0, 8'd0, 8'd0);
        chk("reset.running", 0, 32'(running), 0);
        chk("reset.done", 0, 32'(done), 0);
        chk("reset.alarm", 0, 32'(alarm), 0);
        chk("reset.overflow", 0, 32'(overflow), 0);
        chk("reset.lap_valid", 0, 32'(lap_valid), 0);
        chk("reset.lap", 0, {16'd0, lap_msb, lap_lsb}, 0);
        rst_n = 1'b1;

        // stopwatch run / pause / resume
        mode_sel = 1'b0;
        cyc(1, 0, 0, 0);
        chk("sw_start.running", 0, 32'(running), 1);
        repeat (100) cyc(0, 1, 0, 0);
        chk_cnt("sw_100", 0, 8'd0, 8'd1);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        chk_cnt("sw_pause", 0, 8'd0, 8'd1);
        chk("sw_pause.running", 0, 32'(running), 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk_cnt("sw_resume", 0, 8'd1, 8'd1);

        // stopwatch wrap at 99:99
        cyc(0, 0, 0, 1);
        chk_cnt("sw_clear", 0, 8'd0, 8'd0);
        cyc(1, 0, 0, 0);
        repeat (9999) cyc(0, 1, 0, 0);
        chk_cnt("sw_max", 0, 8'd99, 8'd99);
        chk("sw_max.overflow", 0, 32'(overflow), 0);
        cyc(0, 1, 0, 0);
        chk_cnt("sw_wrap", 0, 8'd0, 8'd0);
        chk("sw_wrap.overflow", 0, 32'(overflow), 1);
        chk("sw_wrap.running", 0, 32'(running), 1);
        cyc(0, 0, 0, 0);
        chk("sw_wrap.overflow_drop", 0, 32'(overflow), 0);

        // lap with simultaneous tick at 3:10, then clear mid-run at 4:20
        repeat (310) cyc(0, 1, 0, 0);
        chk_cnt("sw_310", 0, 8'd10, 8'd3);
        cyc(0, 1, 1, 0);
        chk_cnt("lap_tick.count", 0, 8'd11, 8'd3);
        chk("lap_tick.lap", 0, {16'd0, lap_msb, lap_lsb}, {16'd0, 8'd3, 8'd10});
        chk("lap_tick.valid", 0, 32'(lap_valid), 1);
        repeat (109) cyc(0, 1, 0, 0);
        chk_cnt("sw_420", 0, 8'd20, 8'd4);
        cyc(0, 1, 0, 1);
        chk_cnt("clear_run", 0, 8'd0, 8'd0);
        chk("clear_run.running", 0, 32'(running), 0);
        chk("clear_run.lap_valid", 0, 32'(lap_valid), 0);

        // timer 1:02 down to done
        mode_sel   = 1'b1;
        preset_lsb = 8'd2;
        preset_msb = 8'd1;
        cyc(0, 0, 0, 0);
        chk_cnt("tmr_idle", 0, 8'd2, 8'd1);
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        chk_cnt("tmr_3", 0, 8'd59, 8'd0);
        repeat (58) cyc(0, 1, 0, 0);
        chk_cnt("tmr_01", 0, 8'd1, 8'd0);
        chk("tmr_01.done", 0, 32'(done), 0);
        cyc(0, 1, 0, 0);
        chk_cnt("tmr_zero", 0, 8'd0, 8'd0);
        chk("tmr_zero.done", 0, 32'(done), 1);
        chk("tmr_zero.alarm", 0, 32'(alarm), 1);
        chk("tmr_zero.running", 0, 32'(running), 0);
        cyc(0, 1, 0, 0);
        chk("tmr_hold.done", 0, 32'(done), 0);
        chk("tmr_hold.alarm", 0, 32'(alarm), 1);
        chk_cnt("tmr_hold", 0, 8'd0, 8'd0);
        cyc(1, 0, 0, 0);
        chk("tmr_ack.alarm", 0, 32'(alarm), 0);
        cyc(0, 0, 0, 0);
        chk_cnt("tmr_reload", 0, 8'd2, 8'd1);

        // table: timer edge cases and simultaneous events
        for (int i = 0; i < 15; i++) begin
            mode_sel   = vecs[i].mode;
            preset_lsb = vecs[i].pl;
            preset_msb = vecs[i].pm;
            cyc(vecs[i].ss, vecs[i].tick, vecs[i].lp, vecs[i].clr);
            chk_cnt("vec", i, vecs[i].el, vecs[i].em);
            chk("vec.running", i, 32'(running), 32'(vecs[i].er));
            chk("vec.done", i, 32'(done), 32'(vecs[i].ed));
            chk("vec.alarm", i, 32'(alarm), 32'(vecs[i].ea));
            chk("vec.overflow", i, 32'(overflow), 32'(vecs[i].eo));
            chk("vec.lap_valid", i, 32'(lap_valid), 32'(vecs[i].ev));
            chk("vec.lap", i, {16'd0, lap_msb, lap_lsb}, {16'd0, vecs[i].elm, vecs[i].ell});
        end

        // asynchronous reset mid-run
        mode_sel = 1'b0;
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk_cnt("pre_rst", 0, 8'd6, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt("async_rst", 0, 8'd0, 8'd0);
        chk("async_rst.running", 0, 32'(running), 0);
        chk("async_rst.lap", 0, {15'd0, lap_valid, lap_msb, lap_lsb}, 0);
        chk("async_rst.flags", 0, {28'd0, done, alarm, overflow, running}, 0);
        #3;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
